// File: rtl/multsigned_dot_seq.sv
// multsigned_dot_seq
// Sequencer around one external multsigned_array. Operand beats arrive over
// valid/ready and are registered into the array inputs (S1). The array's
// partial products are reduced per lane and summed across lanes (S2), then
// added into a signed accumulator (S3). The final sum is returned over
// valid/ready.
//
// Build option: define MULTSIGNED_DOT_SAT_EN to make the accumulator
// saturate on signed overflow, stay saturated for the rest of the job and
// report it on the extra output sat_o. Without it the accumulator wraps
// modulo 2^ACC_W and sat_o does not exist.
module multsigned_dot_seq #(
    parameter int  IN_SIZE_0  = 4,
    parameter int  IN_SIZE_1  = 8,
    parameter int  SIZE_ARRAY = 8,
    parameter int  ACC_W      = 32,
    parameter int  LEN_W      = 16,
    localparam int NPP        = (IN_SIZE_1 + 2) / 3,
    localparam int PW         = IN_SIZE_0 + IN_SIZE_1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    output logic                 busy_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_SIZE_0-1:0] in_0_i     [0:SIZE_ARRAY-1],
    input  logic [IN_SIZE_1-1:0] in_1_i     [0:SIZE_ARRAY-1],
    output logic [IN_SIZE_0-1:0] arr_in_0_o [0:SIZE_ARRAY-1],
    output logic [IN_SIZE_1-1:0] arr_in_1_o [0:SIZE_ARRAY-1],
    input  logic [PW-1:0]        arr_pp_i   [0:NPP*SIZE_ARRAY-1],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_W-1:0]     out_data_o
`ifdef MULTSIGNED_DOT_SAT_EN
    ,
    output logic                 sat_o
`endif
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

`ifdef MULTSIGNED_DOT_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;

    // S1: registered operands feeding the array
    logic                 s1_vld_q, s1_vld_d;
    logic [IN_SIZE_0-1:0] s1_in_0_q [0:SIZE_ARRAY-1];
    logic [IN_SIZE_0-1:0] s1_in_0_d [0:SIZE_ARRAY-1];
    logic [IN_SIZE_1-1:0] s1_in_1_q [0:SIZE_ARRAY-1];
    logic [IN_SIZE_1-1:0] s1_in_1_d [0:SIZE_ARRAY-1];

    // S2: cross-lane sum of the current beat
    logic               s2_vld_q, s2_vld_d;
    logic [ACC_W-1:0]   s2_sum_q, s2_sum_d;

    // S3: accumulator and result register
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   out_data_q, out_data_d;

`ifdef MULTSIGNED_DOT_SAT_EN
    logic               sat_q, sat_d;
    logic               sat_out_q, sat_out_d;
    logic               acc_ovf;
`endif

    // Combinational reduction results
    logic [ACC_W-1:0]   lane_ext [0:SIZE_ARRAY-1];
    logic [ACC_W-1:0]   beat_sum;

    // Handshake strobes
    logic               in_ready;
    logic               beat_acc;
    logic               job_start;

    assign in_ready  = (state_q == ST_RUN) && (cnt_q < len_q);
    assign beat_acc  = in_ready && in_valid_i;
    assign job_start = (state_q == ST_IDLE) && start_i;

    // Per-lane reduction: the partial products of a lane add up (mod 2^PW)
    // to the exact signed product, which is then sign-extended to ACC_W.
    for (genvar gi = 0; gi < SIZE_ARRAY; gi++) begin : g_lane
        logic [PW-1:0] prod;

        // Sum this lane's NPP partial products modulo 2^PW
        always_comb begin
            prod = '0;
            for (int k = 0; k < NPP; k++) begin
                prod = prod + arr_pp_i[gi*NPP + k];
            end
        end

        assign lane_ext[gi] = {{(ACC_W-PW){prod[PW-1]}}, prod};
    end

    // Sum all sign-extended lane products of the beat held in S1
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            beat_sum = beat_sum + lane_ext[i];
        end
    end

    // Job sequencing: start capture, beat counting, drain wait, response
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
`ifdef MULTSIGNED_DOT_SAT_EN
        sat_out_d  = sat_out_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    len_d = len_i;
                    cnt_d = '0;
                    if (len_i == '0) begin
                        // Empty job answers immediately with a zero sum
                        state_d    = ST_RESP;
                        out_data_d = '0;
`ifdef MULTSIGNED_DOT_SAT_EN
                        sat_out_d  = 1'b0;
`endif
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (beat_acc) begin
                    // cnt_q < len_q here, so the increment never wraps
                    cnt_d = cnt_q + LEN_ONE;
                    if (cnt_q == len_q - LEN_ONE) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Once S1 and S2 are empty the accumulator holds the final sum
                if (!s1_vld_q && !s2_vld_q) begin
                    state_d    = ST_RESP;
                    out_data_d = acc_q;
`ifdef MULTSIGNED_DOT_SAT_EN
                    sat_out_d  = sat_q;
`endif
                end
            end
            ST_RESP: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pipeline advance: S1 loads on accepted beats, S2 captures the beat sum
    always_comb begin
        s1_vld_d  = beat_acc;
        s1_in_0_d = s1_in_0_q;
        s1_in_1_d = s1_in_1_q;
        if (beat_acc) begin
            s1_in_0_d = in_0_i;
            s1_in_1_d = in_1_i;
        end
        s2_vld_d = s1_vld_q;
        s2_sum_d = s1_vld_q ? beat_sum : s2_sum_q;
    end

    // S3 accumulation, cleared at job start
    always_comb begin
        acc_d   = acc_q;
        acc_sum = acc_q + s2_sum_q;
`ifdef MULTSIGNED_DOT_SAT_EN
        sat_d   = sat_q;
        // Signed overflow: operands share a sign that the sum does not
        acc_ovf = (acc_q[ACC_W-1] == s2_sum_q[ACC_W-1]) &&
                  (acc_sum[ACC_W-1] != acc_q[ACC_W-1]);
`endif
        if (job_start) begin
            acc_d = '0;
`ifdef MULTSIGNED_DOT_SAT_EN
            sat_d = 1'b0;
`endif
        end else if (s2_vld_q) begin
`ifdef MULTSIGNED_DOT_SAT_EN
            // Once saturated the value is frozen for the rest of the job
            if (!sat_q) begin
                if (acc_ovf) begin
                    acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
                    sat_d = 1'b1;
                end else begin
                    acc_d = acc_sum;
                end
            end
`else
            acc_d = acc_sum;
`endif
        end
    end

    // Control state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            out_data_q <= '0;
`ifdef MULTSIGNED_DOT_SAT_EN
            sat_out_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
`ifdef MULTSIGNED_DOT_SAT_EN
            sat_out_q  <= sat_out_d;
`endif
        end
    end

    // S1 operand registers driving the array
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld_q <= 1'b0;
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                s1_in_0_q[i] <= '0;
                s1_in_1_q[i] <= '0;
            end
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_in_0_q <= s1_in_0_d;
            s1_in_1_q <= s1_in_1_d;
        end
    end

    // S2 beat-sum register and S3 accumulator
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_vld_q <= 1'b0;
            s2_sum_q <= '0;
            acc_q    <= '0;
`ifdef MULTSIGNED_DOT_SAT_EN
            sat_q    <= 1'b0;
`endif
        end else begin
            s2_vld_q <= s2_vld_d;
            s2_sum_q <= s2_sum_d;
            acc_q    <= acc_d;
`ifdef MULTSIGNED_DOT_SAT_EN
            sat_q    <= sat_d;
`endif
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign in_ready_o  = in_ready;
    assign out_valid_o = (state_q == ST_RESP);
    assign out_data_o  = out_data_q;
    assign arr_in_0_o  = s1_in_0_q;
    assign arr_in_1_o  = s1_in_1_q;
`ifdef MULTSIGNED_DOT_SAT_EN
    assign sat_o       = sat_out_q;
`endif

endmodule

// File: tb/tb_multsigned_dot_seq.sv
// Bench for multsigned_dot_seq: two instances (ACC_W=32 and ACC_W=16) share
// the stimulus; a behavioural array model supplies partial products and a
// dot-product model predicts each job's result.
module tb_multsigned_dot_seq;
    localparam int IN0 = 4;
    localparam int IN1 = 8;
    localparam int SA  = 8;
    localparam int LW  = 16;
    localparam int NPP = (IN1 + 2) / 3;
    localparam int PW  = IN0 + IN1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [LW-1:0]  len_i = '0;
    logic           in_valid_i = 1'b0;
    logic           out_ready_i = 1'b0;
    logic [IN0-1:0] in_0_i [0:SA-1];
    logic [IN1-1:0] in_1_i [0:SA-1];

    logic [IN0-1:0] a0_32 [0:SA-1];
    logic [IN1-1:0] a1_32 [0:SA-1];
    logic [IN0-1:0] a0_16 [0:SA-1];
    logic [IN1-1:0] a1_16 [0:SA-1];
    logic [PW-1:0]  pp32  [0:NPP*SA-1];
    logic [PW-1:0]  pp16  [0:NPP*SA-1];
    logic           busy32, busy16, rdy32, rdy16, ov32, ov16;
    logic [31:0]    od32;
    logic [15:0]    od16;
`ifdef MULTSIGNED_DOT_SAT_EN
    logic           sat32, sat16;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_edge = 0;
    int ref_edge  = 0;

    // Model state
    logic [31:0] m32, exp32, held32;
    logic [15:0] m16, exp16, held16;
    bit          msat32, msat16, exp_sat32, exp_sat16;
    bit          exp_pending = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multsigned_dot_seq u_dut32 (
        .clk_i (clk), .rst_ni (rst_n), .start_i (start_i), .len_i (len_i),
        .busy_o (busy32), .in_valid_i (in_valid_i), .in_ready_o (rdy32),
        .in_0_i (in_0_i), .in_1_i (in_1_i),
        .arr_in_0_o (a0_32), .arr_in_1_o (a1_32), .arr_pp_i (pp32),
        .out_valid_o (ov32), .out_ready_i (out_ready_i), .out_data_o (od32)
`ifdef MULTSIGNED_DOT_SAT_EN
        , .sat_o (sat32)
`endif
    );

    multsigned_dot_seq #(.ACC_W(16)) u_dut16 (
        .clk_i (clk), .rst_ni (rst_n), .start_i (start_i), .len_i (len_i),
        .busy_o (busy16), .in_valid_i (in_valid_i), .in_ready_o (rdy16),
        .in_0_i (in_0_i), .in_1_i (in_1_i),
        .arr_in_0_o (a0_16), .arr_in_1_o (a1_16), .arr_pp_i (pp16),
        .out_valid_o (ov16), .out_ready_i (out_ready_i), .out_data_o (od16)
`ifdef MULTSIGNED_DOT_SAT_EN
        , .sat_o (sat16)
`endif
    );

    // Array model: operand 1 split into 3-bit digits (top digit signed);
    // each partial product is a * digit * 8^k, so they sum to a*b.
    function automatic logic [PW-1:0] pp_entry(input logic [IN0-1:0] a,
                                               input logic [IN1-1:0] b,
                                               input int k);
        int av, bv, digit;
        av = int'($signed(a));
        bv = int'($signed(b));
        if (k == NPP - 1) digit = bv >>> (3 * k);
        else              digit = (bv >>> (3 * k)) & 7;
        return PW'(av * digit * (1 << (3 * k)));
    endfunction

    always_comb begin
        for (int l = 0; l < SA; l++) begin
            for (int k = 0; k < NPP; k++) begin
                pp32[l*NPP + k] = pp_entry(a0_32[l], a1_32[l], k);
                pp16[l*NPP + k] = pp_entry(a0_16[l], a1_16[l], k);
            end
        end
    end

    task automatic check(input bit ok, input string name, input longint act, input longint req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // Compare process: every cycle a result is presented it must be expected
    // and equal the model's value.
    always @(negedge clk) begin
        if (rst_n && (ov32 || ov16)) begin
            check(exp_pending && ov32 && ov16, "out_valid_expected", longint'(ov32), 1);
            if (exp_pending) begin
                check(od32 === exp32, "data32", od32, exp32);
                check(od16 === exp16, "data16", od16, exp16);
`ifdef MULTSIGNED_DOT_SAT_EN
                check(sat32 === exp_sat32, "sat32", sat32, exp_sat32);
                check(sat16 === exp_sat16, "sat16", sat16, exp_sat16);
`endif
            end
        end
    end

    task automatic model_reset();
        m32 = '0; m16 = '0; msat32 = 1'b0; msat16 = 1'b0;
    endtask

    // Fold one accepted beat (current in_0_i/in_1_i) into the model
    task automatic model_beat();
        int bs;
        longint t;
        bs = 0;
        for (int l = 0; l < SA; l++) bs += int'($signed(in_0_i[l])) * int'($signed(in_1_i[l]));
`ifdef MULTSIGNED_DOT_SAT_EN
        if (!msat32) begin
            t = longint'($signed(m32)) + longint'(bs);
            if (t > (longint'(1) << 31) - 1) begin m32 = 32'h7fff_ffff; msat32 = 1'b1; end
            else if (t < -(longint'(1) << 31)) begin m32 = 32'h8000_0000; msat32 = 1'b1; end
            else m32 = 32'(t);
        end
        if (!msat16) begin
            t = longint'($signed(m16)) + longint'(bs);
            if (t > 32767) begin m16 = 16'h7fff; msat16 = 1'b1; end
            else if (t < -32768) begin m16 = 16'h8000; msat16 = 1'b1; end
            else m16 = 16'(t);
        end
`else
        t = 0;
        m32 = m32 + 32'(bs + int'(t));
        m16 = m16 + 16'(bs);
`endif
    endtask

    // Offer beats until n are accepted. gap: 0 always valid, 1 alternate, 2 random.
    task automatic drive_beats(input int n, input int gap, input int mode);
        int acc_n, tries;
        acc_n = 0;
        tries = 0;
        while (acc_n < n && tries < 400) begin
            case (gap)
                0:       in_valid_i = 1'b1;
                1:       in_valid_i = (tries % 2 == 0);
                default: in_valid_i = 1'($urandom_range(0, 1));
            endcase
            for (int l = 0; l < SA; l++) begin
                case (mode)
                    1:       begin in_0_i[l] = 4'd3;  in_1_i[l] = 8'd5;   end
                    2:       begin in_0_i[l] = 4'h8;  in_1_i[l] = 8'h80;  end
                    3:       begin in_0_i[l] = 4'd7;  in_1_i[l] = 8'd127; end
                    default: begin in_0_i[l] = IN0'($urandom); in_1_i[l] = IN1'($urandom); end
                endcase
            end
            @(negedge clk);
            check(rdy16 === rdy32, "ready_match", rdy16, rdy32);
            if (in_valid_i && rdy32) begin
                model_beat();
                acc_n++;
            end
            @(posedge clk); #1;
            tries++;
        end
        in_valid_i = 1'b0;
        last_edge = cyc;
        check(acc_n == n, "beat_accept_timeout", acc_n, n);
    endtask

    task automatic noise_drive(input bit noise);
        if (noise) begin
            start_i    = 1'($urandom_range(0, 1));
            in_valid_i = 1'($urandom_range(0, 1));
            len_i      = LW'($urandom);
        end
    endtask

    // One complete job: start, beats, result latency, stall, handshake.
    task automatic run_job(input int len, input int mode, input int gap,
                           input int stall, input bit noise);
        int w;
        model_reset();
        if (len == 0) begin
            exp32 = '0; exp16 = '0; exp_sat32 = 1'b0; exp_sat16 = 1'b0;
            exp_pending = 1'b1;
        end
        start_i = 1'b1;
        len_i   = LW'(len);
        @(posedge clk); #1;
        start_i = 1'b0;
        len_i   = LW'($urandom);
        ref_edge = cyc;
        if (len != 0) begin
            drive_beats(len, gap, mode);
            exp32 = m32; exp16 = m16; exp_sat32 = msat32; exp_sat16 = msat16;
            exp_pending = 1'b1;
            ref_edge = last_edge + 3;
        end
        w = 0;
        forever begin
            noise_drive(noise);
            @(negedge clk);
            check(rdy32 === 1'b0 && rdy16 === 1'b0, "no_ready_after_last", rdy32, 0);
            check(busy32 === 1'b1 && busy16 === 1'b1, "busy_in_job", busy32, 1);
            if (ov32 || w >= 50) break;
            @(posedge clk); #1;
            w++;
        end
        check(ov32 && cyc == ref_edge, "result_latency", cyc, ref_edge);
        held32 = od32;
        held16 = od16;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            noise_drive(noise);
            @(negedge clk);
            check(ov32 && od32 === held32 && od16 === held16, "hold_stable", od32, held32);
        end
        @(posedge clk); #1;
        start_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        exp_pending = 1'b0;
        @(negedge clk);
        check(!busy32 && !busy16 && !ov32 && !ov16, "idle_after_handshake", busy32, 0);
        check(od32 === held32, "data_kept_after_handshake", od32, held32);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check(busy32 === 1'b0 && busy16 === 1'b0, {tag, "_busy"}, busy32, 0);
        check(rdy32 === 1'b0 && rdy16 === 1'b0, {tag, "_ready"}, rdy32, 0);
        check(ov32 === 1'b0 && ov16 === 1'b0, {tag, "_out_valid"}, ov32, 0);
        check(od32 === 32'd0, {tag, "_data32"}, od32, 0);
        check(od16 === 16'd0, {tag, "_data16"}, od16, 0);
        for (int l = 0; l < SA; l++) begin
            check(a0_32[l] === '0 && a1_32[l] === '0 && a0_16[l] === '0 && a1_16[l] === '0,
                  {tag, "_arr_in"}, a1_32[l], 0);
        end
`ifdef MULTSIGNED_DOT_SAT_EN
        check(sat32 === 1'b0 && sat16 === 1'b0, {tag, "_sat"}, sat32, 0);
`endif
    endtask

    // Watchdog: a hung run still ends with a FAIL line
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < SA; l++) begin
            in_0_i[l] = '0;
            in_1_i[l] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 8 lanes of 3*5
        run_job(1, 1, 0, 0, 1'b0);
        check(exp32 == 32'd120, "model_len1", exp32, 120);
        check(held32 === 32'd120, "lit_len1_32", held32, 120);
        check(held16 === 16'd120, "lit_len1_16", held16, 120);

        // Most negative operands, 4 beats
        run_job(4, 2, 0, 0, 1'b0);
        check(exp32 == 32'd32768, "model_minneg", exp32, 32768);
        check(held32 === 32'd32768, "lit_minneg_32", held32, 32768);
`ifdef MULTSIGNED_DOT_SAT_EN
        check(held16 === 16'h7fff, "lit_minneg_16", held16, 16'h7fff);
`else
        check(held16 === 16'h8000, "lit_minneg_16", held16, 16'h8000);
`endif

        // Alternating valid, consumer stalls 5 cycles
        run_job(3, 0, 1, 5, 1'b0);

        // Empty job with noise on start/in_valid
        run_job(0, 0, 0, 2, 1'b1);
        check(held32 === 32'd0, "lit_len0", held32, 0);

        run_job(3, 0, 2, 3, 1'b1);

        // Reset during RUN after 2 of 5 beats
        model_reset();
        start_i = 1'b1;
        len_i   = LW'(5);
        @(posedge clk); #1;
        start_i = 1'b0;
        drive_beats(2, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("midjob_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_job(1, 1, 0, 0, 1'b0);
        check(held32 === 32'd120, "lit_after_reset", held32, 120);

        // 8 beats of 7*127 per lane: 56896 total
        run_job(8, 3, 0, 1, 1'b0);
        check(exp32 == 32'd56896, "model_wrap32", exp32, 56896);
        check(held32 === 32'd56896, "lit_wrap_32", held32, 56896);
`ifdef MULTSIGNED_DOT_SAT_EN
        check(held16 === 16'h7fff, "lit_sat_16", held16, 16'h7fff);
        check(exp_sat16 == 1'b1, "model_sat_flag", exp_sat16, 1);
`else
        check(held16 === 16'hDE40, "lit_wrap_16", held16, 16'hDE40);
`endif

        // Randomized jobs
        for (int j = 0; j < 25; j++) begin
            run_job($urandom_range(0, 7), 0, $urandom_range(0, 2),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        run_job(40, 0, 2, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multsigned_dot_seq.md
Name: multsigned_dot_seq

Overview:
- Sequencer around one external multsigned_array instance that computes a signed dot product over a programmed number of vector beats.
- Accepts operand beats over valid/ready and drives them to the array through a register stage.
- Reduces each lane's partial products to a product and sums the lanes into a signed accumulator.
- Returns the result over valid/ready.
- Sits between the operand fetch logic and the writeback logic of the AI core datapath.

Parameters:
- IN_SIZE_0, 4, signed width of operand 0 (activation).
- IN_SIZE_1, 8, signed width of operand 1 (weight).
- SIZE_ARRAY, 8, number of multiplier lanes per beat.
- ACC_W, 32, accumulator and result width; must be at least IN_SIZE_0+IN_SIZE_1+clog2(SIZE_ARRAY).
- LEN_W, 16, width of the beat-count field.
- Derived: NPP = (IN_SIZE_1+2)/3 partial products per lane; PW = IN_SIZE_0+IN_SIZE_1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle job start pulse
- len_i  in  LEN_W  beats in the job, sampled on an accepted start
- busy_o  out  1  job in progress
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  operand beat accepted this cycle when high together with in_valid_i
- in_0_i  in  IN_SIZE_0 x SIZE_ARRAY  operand-0 vector, unpacked [0:SIZE_ARRAY-1]
- in_1_i  in  IN_SIZE_1 x SIZE_ARRAY  operand-1 vector, unpacked [0:SIZE_ARRAY-1]
- arr_in_0_o  out  IN_SIZE_0 x SIZE_ARRAY  to array in_0_i
- arr_in_1_o  out  IN_SIZE_1 x SIZE_ARRAY  to array in_1_i
- arr_pp_i  in  PW x (NPP*SIZE_ARRAY)  from array out_o; lane i owns entries [i*NPP : i*NPP+NPP-1]
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumer ready
- out_data_o  out  ACC_W  signed dot-product result

Behaviour:
- Reset values: busy_o=0, in_ready_o=0, out_valid_o=0, out_data_o=0, arr_in_0_o=0, arr_in_1_o=0. Pipeline valid bits, accumulator and beat counter are cleared. Reset asserted mid-job aborts the job with no output.
- FSM states: IDLE, RUN, DRAIN, RESP.
- IDLE:
  - A start_i pulse captures len_i and clears the accumulator and counter.
  - If len_i=0, go to RESP with out_data_o=0 on the next cycle.
  - Otherwise go to RUN.
  - busy_o=1 in every state except IDLE.
  - start_i outside IDLE is ignored.
- RUN:
  - in_ready_o = 1 while the accepted-beat count < len.
  - Each accepted beat is registered into arr_in_*_o (stage S1) and the count increments.
  - When the last beat is accepted, go to DRAIN.
- S2 (stage after S1):
  - For each lane, sum its NPP partial products modulo 2^PW. The result is the exact signed lane product.
  - Sign-extend each lane product to ACC_W, sum all lanes, and register the result with a valid bit.
- S3 (stage after S2): when S2 is valid, acc <= acc + S2 sum, modulo 2^ACC_W.
- DRAIN:
  - Wait until S1 and S2 are both empty, then move acc to out_data_o and go to RESP.
  - Latency: the result becomes valid exactly 3 cycles after the last beat is accepted.
- RESP:
  - out_valid_o=1 and out_data_o is held stable until out_ready_i.
  - On the handshake, go to IDLE with busy_o=0. out_data_o keeps its last value.
- Other rules:
  - Gaps in in_valid_i stall nothing downstream; bubbles propagate as invalid S1/S2 entries.
  - in_valid_i while not in RUN is ignored and in_ready_o=0.
  - A count of len=2^LEN_W-1 must complete with no counter wrap.
  - out_valid_o never asserts for a job started with no reset between start and result, except through the normal RESP path.

Optional Feature:
- Macro: MULTSIGNED_DOT_SAT_EN.
- Defined:
  - The S3 accumulation saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1) on signed overflow.
  - Saturation is sticky for the rest of the job: once saturated, further beats cannot pull the value back.
  - An extra output sat_o (1 bit, reset 0) is valid with out_valid_o.
- Not defined: accumulation wraps modulo 2^ACC_W, and sat_o does not exist.

Test Plan:
- len=1, in_0 all lanes 3, in_1 all lanes 5 → out_data_o=120 exactly 3 cycles after the beat handshake. busy_o falls the cycle after out_ready_i.
- len=4, lane i per beat in_0=-8, in_1=-128 (most negative values) → each lane product 1024, total 4*8*1024=32768.
- len=3 with in_valid_i toggling every other cycle and out_ready_i held low 5 cycles after out_valid_o → result correct, out_data_o stable while stalled, no extra beats accepted beyond 3.
- len=0 start → out_valid_o the next cycle with out_data_o=0. in_ready_o never asserts.
- start_i pulses while busy and in_valid_i outside RUN → ignored. rst_ni asserted during RUN after 2 of 5 beats → all outputs at reset values, a new len=1 job afterwards returns the correct fresh result.
- ACC_W=16 with len=8 of products 7*127 per lane (56896 total) → wraps to -8640 without MULTSIGNED_DOT_SAT_EN. With the macro: 32767 and sat_o=1.
